// File: rtl/pmo_anim_pkg.sv
// Shared definitions for the pet animation path: source-select encodings,
// request bit positions and the fixed-priority winner helper.
package pmo_anim_pkg;

  // Sprite source driven onto anim_sel
  typedef enum logic [1:0] {
    ANIM_IDLE  = 2'd0,
    ANIM_EAT   = 2'd1,
    ANIM_PLAY  = 2'd2,
    ANIM_SLEEP = 2'd3
  } anim_t;

  // Scheduler states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // Bit positions of the action request / pending vectors
  localparam int REQ_EAT   = 0;
  localparam int REQ_PLAY  = 1;
  localparam int REQ_SLEEP = 2;

  // Fixed priority: sleep > eat > play; idle when nothing is offered
  function automatic anim_t pick_winner(input logic [2:0] avail);
    anim_t w;
    if (avail[REQ_SLEEP]) begin
      w = ANIM_SLEEP;
    end else if (avail[REQ_EAT]) begin
      w = ANIM_EAT;
    end else if (avail[REQ_PLAY]) begin
      w = ANIM_PLAY;
    end else begin
      w = ANIM_IDLE;
    end
    return w;
  endfunction

  // Request/pending bit that belongs to an animation source
  function automatic logic [2:0] anim_bit(input anim_t a);
    logic [2:0] b;
    case (a)
      ANIM_EAT:   b = 3'b001;
      ANIM_PLAY:  b = 3'b010;
      ANIM_SLEEP: b = 3'b100;
      default:    b = 3'b000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/anim_sched_frame_ticker.sv
// frame_ticker: free-running prescaler that yields the per-frame enable.
// wrap is the combinational terminal count (the edge on which frames
// advance); frame_tick is its registered one-cycle copy. clr restarts the
// count so a newly granted animation gets a full first frame.
module frame_ticker #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap,
  output logic frame_tick
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] count;

  assign wrap = (count == CNT_W'(TICK_DIV - 1));

  // Prescaler count and registered frame enable
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= {CNT_W{1'b0}};
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (clr || wrap) begin
        count <= {CNT_W{1'b0}};
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/anim_sched.sv
// anim_sched: queues eat/play/sleep requests, grants them by fixed priority
// and plays each for LOOPS passes of FRAMES frames; loops the idle sprite
// otherwise. Optional feature macro: ANIM_SCHED_ABORT_EN (adds abort input
// that cancels the running action and flushes the queue).
module anim_sched
  import pmo_anim_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int FRAMES   = 16,
  parameter int STEP_W   = 4,
  parameter int LOOPS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
`ifdef ANIM_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic [1:0]        anim_sel,
  output logic [STEP_W-1:0] step,
  output logic              frame_tick,
  output logic              busy,
  output logic              done
);
  localparam int                LOOP_W    = $clog2(LOOPS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        pend;
  logic [2:0]        pend_nxt;
  logic [2:0]        avail;
  logic [LOOP_W-1:0] loop;
  logic [LOOP_W-1:0] loop_nxt;
  logic [STEP_W-1:0] step_nxt;
  anim_t             winner;
  anim_t             sel_nxt;
  logic              wrap;
  logic              clr;
  logic              last_frame;
  logic              finish;
  logic              abort_hit;
  logic              grant;
  logic              done_nxt;

  frame_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wrap       (wrap),
    .frame_tick (frame_tick)
  );

  // A request offered this cycle competes alongside the queued ones
  assign avail      = pend | req;
  assign winner     = pick_winner(avail);
  assign last_frame = wrap && (step == STEP_LAST);
  assign finish     = (state == ST_PLAY) && last_frame && (loop == LOOP_LAST);
`ifdef ANIM_SCHED_ABORT_EN
  assign abort_hit  = (state == ST_PLAY) && abort;
`else
  assign abort_hit  = 1'b0;
`endif
  assign grant = !abort_hit && (avail != 3'b000) &&
                 ((state == ST_IDLE) || finish);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (avail != 3'b000) begin
          state_nxt = ST_PLAY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (abort_hit || (finish && (avail == 3'b000))) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of step, loop, queue, source select and completion pulse
  always_comb begin
    step_nxt = step;
    loop_nxt = loop;
    pend_nxt = avail;
    sel_nxt  = anim_t'(anim_sel);
    done_nxt = 1'b0;
    clr      = 1'b0;
    if (abort_hit) begin
      // Cancel: requests arriving with abort are flushed with the queue
      step_nxt = {STEP_W{1'b0}};
      loop_nxt = {LOOP_W{1'b0}};
      pend_nxt = 3'b000;
      sel_nxt  = ANIM_IDLE;
      clr      = 1'b1;
    end else if (grant) begin
      // New action starts; its own request is absorbed, not queued
      step_nxt = {STEP_W{1'b0}};
      loop_nxt = {LOOP_W{1'b0}};
      pend_nxt = avail & ~anim_bit(winner);
      sel_nxt  = winner;
      clr      = 1'b1;
      done_nxt = finish;
    end else if (finish) begin
      step_nxt = {STEP_W{1'b0}};
      loop_nxt = {LOOP_W{1'b0}};
      sel_nxt  = ANIM_IDLE;
      done_nxt = 1'b1;
    end else if (last_frame) begin
      // End of a pass: idle simply wraps, an action counts the pass
      step_nxt = {STEP_W{1'b0}};
      if (state == ST_PLAY) begin
        loop_nxt = loop + LOOP_W'(1);
      end else begin
        loop_nxt = loop;
      end
    end else if (wrap) begin
      step_nxt = step + STEP_W'(1);
    end else begin
      step_nxt = step;
    end
  end

  // Registered outputs and scheduler datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_sel <= ANIM_IDLE;
      step     <= {STEP_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      pend     <= 3'b000;
      loop     <= {LOOP_W{1'b0}};
    end else begin
      anim_sel <= sel_nxt;
      step     <= step_nxt;
      busy     <= (sel_nxt != ANIM_IDLE);
      done     <= done_nxt;
      pend     <= pend_nxt;
      loop     <= loop_nxt;
    end
  end

endmodule

// File: doc/anim_sched.md
# anim_sched

Animation scheduler for the pet display path. It owns the frame-step counter and the animation-source select that drive the sprite memories (idle, eat, play, sleep) read by the VGA pixel pipeline. Action requests from the game FSM are queued and arbitrated by priority, and each one is played for a fixed number of frames. When no action is pending, the scheduler falls back to the looping idle animation. It produces a single-cycle frame-tick enable; no derived clocks leave this block.

## Interface
Parameters:
- TICK_DIV, 10_000_000, clk cycles per animation frame (min 2)
- FRAMES, 16, frames per animation pass (min 2, ≤ 2^STEP_W)
- STEP_W, 4, width of step
- LOOPS, 2, passes of FRAMES played per action request (min 1)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous, active-high reset
- req, in, 3, action request levels: [0] eat, [1] play, [2] sleep; sampled every cycle
- anim_sel, out, 2, active source: 0 idle, 1 eat, 2 play, 3 sleep
- step, out, STEP_W, frame index into the selected sprite memory
- frame_tick, out, 1, one-cycle enable once per TICK_DIV cycles
- busy, out, 1, high while an action animation plays (anim_sel ≠ 0)
- done, out, 1, one-cycle pulse when an action animation completes
- abort, in, 1, present only with ANIM_SCHED_ABORT_EN

## Operation
- States:
  - IDLE: anim_sel = 0.
  - PLAY: anim_sel = active action.
- Pending register is 3 bits. Any cycle with req[i] = 1 sets pend[i], except when that type is granted in the same cycle, in which case the request is absorbed.
- Priority is fixed: sleep > eat > play.
- IDLE:
  - step advances on each frame_tick and wraps from FRAMES-1 to 0.
  - If (pend | req) ≠ 0, the next edge enters PLAY with the winner. That edge sets step = 0, loop = 0, prescaler = 0, busy = 1, and clears pend[winner].
- PLAY:
  - step advances on frame_tick.
  - At step = FRAMES-1 with frame_tick, if loop < LOOPS-1: step = 0 and loop increments.
  - If loop = LOOPS-1 at that point: done = 1 for one cycle, then:
    - if (pend | req) ≠ 0: grant the next winner (same reset of step, loop and prescaler) and stay in PLAY;
    - otherwise: enter IDLE with step = 0 and busy = 0.
- A request for the active type during PLAY is queued and replays after completion.
- Widths:
  - loop counter: $clog2(LOOPS+1) bits;
  - prescaler: $clog2(TICK_DIV) bits;
  - step compare against FRAMES-1, evaluated at STEP_W bits.

## Timing
- Reset values: anim_sel = 0, step = 0, frame_tick = 0, busy = 0, done = 0, pend = 0, loop = 0, prescaler = 0. State = IDLE.
- rst mid-animation takes effect on the next edge. Queued requests are discarded.
- Prescaler counts 0..TICK_DIV-1. frame_tick is registered high in the cycle after the count reaches TICK_DIV-1, and step updates on that same edge.
- Grant latency: req high at edge N means anim_sel, step = 0 and busy are valid after edge N+1.
- The first frame of every granted animation lasts exactly TICK_DIV cycles, because the prescaler restarts on grant.
- Action duration: LOOPS·FRAMES·TICK_DIV cycles from grant to the done edge.
- done coincides with the cycle anim_sel changes. Back-to-back actions have no IDLE gap.

## Configuration
- ANIM_SCHED_ABORT_EN defined:
  - adds the abort input;
  - abort = 1 in PLAY: next edge enters IDLE, step = 0, pend = 0, done = 0, prescaler reset;
  - abort has priority over completion in the same cycle;
  - abort is ignored in IDLE, and req in the same cycle as abort is dropped.
- Undefined: no abort port; actions always run to completion.

## Structure
- Shared package pmo_anim_pkg holds:
  - anim_sel encodings ANIM_IDLE / ANIM_EAT / ANIM_PLAY / ANIM_SLEEP;
  - the REQ_EAT / REQ_PLAY / REQ_SLEEP bit indices.
- Sub-module frame_ticker: prescaler with a synchronous clear input, producing frame_tick. It replaces clock-divider-derived clocks in this path.

## Test plan
Bench parameters: TICK_DIV = 4, FRAMES = 16, LOOPS = 2.
- Reset, then idle for 200 cycles → anim_sel = 0, busy = 0; step increments every 4 cycles and wraps 15→0.
- One-cycle req = 3'b001 in IDLE → next cycle anim_sel = 1, step = 0, busy = 1. done pulses exactly 128 cycles later, then anim_sel = 0 and step = 0.
- req = 3'b111 held for one cycle in IDLE → sleep granted first, then eat, then play, back to back. Each done pulse is 128 cycles apart and busy never drops between them.
- rst asserted at step 7 of a play animation, with eat pending → next cycle all outputs are at reset values, and no eat plays afterwards.
- req[1] re-pulsed during an active play → play runs twice, with done pulses at 128 and 256 cycles.
- With ANIM_SCHED_ABORT_EN: abort at step 5 with sleep pending → next cycle anim_sel = 0, done = 0; sleep is never granted.
